psum_bank_ctrl: RTL and testbench
=================================

Name: psum_bank_ctrl

Overview:
Multi-bank controller for the partial-sum SRAM. It replaces the fixed row*col write counter with runtime-programmable tile lengths. It splits the psum SRAM into NUM_BANK ping-pong regions, so the OFIFO/SFP writer can fill one tile while the IFIFO loader drains an earlier one. It drives the single-port psum SRAM (active-low CEN/WEN, 1-cycle read latency), arbitrates write versus read, and produces per-tile done/ready handshakes.

Parameters:
- NUM_BANK, 2, number of tile banks; power of two, at least 2.
- BANK_DEPTH, 64, maximum entries per tile; power of two.
- ADD_WIDTH, 11, psum SRAM address width; NUM_BANK*BANK_DEPTH must not exceed 2**ADD_WIDTH.
- LEN_W, 7, tile_len width; equals clog2(BANK_DEPTH)+1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- tile_len  in  LEN_W  entries in the next tile; sampled on the first write of each bank
- wr_valid  in  1  writer has a psum word this cycle
- wr_ready  out  1  write accepted this cycle
- rd_req  in  1  loader requests the next psum word
- rd_gnt  out  1  read issued to the SRAM this cycle
- rd_data_valid  out  1  SRAM Q is valid (one cycle after rd_gnt)
- rd_last  out  1  qualifies rd_data_valid; last word of the tile
- sram_cen  out  1  psum SRAM chip enable, active low
- sram_wen  out  1  psum SRAM write enable, active low
- sram_addr  out  ADD_WIDTH  psum SRAM address
- tile_done  out  1  one-cycle pulse when a bank finishes filling
- tile_ready  out  1  the bank at the read pointer holds a complete tile
- all_full  out  1  no bank is available for writing
- all_empty  out  1  every bank is EMPTY

Behaviour:
- Per-bank state is 2-bit: EMPTY, FILLING, FULL, DRAINING. Each bank also holds a stored length len_q[b].
- Pointers: wr_bank, rd_bank, wr_cnt, rd_cnt. Pointers wrap modulo NUM_BANK.
- Effective length: tile_len of 0, or any value above BANK_DEPTH, becomes BANK_DEPTH.
- Write side:
  - wr_ready = !reset and state[wr_bank] is EMPTY or FILLING.
  - On a write handshake:
    - sram_cen=0, sram_wen=0, sram_addr = wr_bank*BANK_DEPTH + wr_cnt.
    - First write (wr_cnt==0): latch len_q and set the state to FILLING.
    - If wr_cnt == len-1: state becomes FULL, wr_cnt resets to 0, wr_bank advances, and tile_done pulses on the next cycle.
- Read side:
  - tile_ready = state[rd_bank] is FULL or DRAINING.
  - rd_gnt = rd_req & tile_ready & !(write handshake this cycle). Writes have priority and a blocked read simply retries.
  - On rd_gnt:
    - sram_cen=0, sram_wen=1, sram_addr = rd_bank*BANK_DEPTH + rd_cnt.
    - State becomes DRAINING.
    - If rd_cnt == len_q-1: state becomes EMPTY, rd_cnt resets to 0, rd_bank advances, and rd_last is registered with rd_data_valid.
  - rd_data_valid is rd_gnt delayed one cycle.
- Idle cycle: sram_cen=1, sram_wen=1, sram_addr holds its last value.
- A bank that is written full while rd_bank points to it becomes tile_ready on the next cycle; there is no same-cycle bypass.
- A bank freed by the last read becomes writable on the next cycle.
- Status flags:
  - all_full = no bank is EMPTY or FILLING at wr_bank (wr_ready low for lack of space).
  - all_empty = every state is EMPTY.
- Reset (synchronous, mid-operation included):
  - All banks go EMPTY; pointers, counters and len_q clear.
  - Outputs during and after reset: sram_cen=1, sram_wen=1, sram_addr=0, tile_done=0, rd_data_valid=0, rd_last=0, rd_gnt=0, wr_ready=0 while reset is high, all_empty=1.
  - In-flight reads are dropped.
- Throughput: one SRAM access per cycle; sustained write and read interleave.

Optional Feature:
- Macro: PSUM_TILE_STATS_EN.
- Defined: adds outputs tiles_written[15:0] and tiles_drained[15:0].
  - tiles_written increments on tile_done; tiles_drained increments on the rd_last beat.
  - Both wrap at 16 bits and clear on reset.
- Undefined: the ports and counters are absent and the remaining behaviour is unchanged.

Decomposition:
- Shared package psum_pkg holds:
  - bank_state_t enum: EMPTY=0, FILLING=1, FULL=2, DRAINING=3.
  - Constants PSUM_BANK_DEPTH_DEF=64 and PSUM_NUM_BANK_DEF=2.
  - Function clog2.
- One sub-module, psum_bank_fsm: a per-bank state and len_q register, instantiated NUM_BANK times via generate. Pointer, arbitration and SRAM muxing stay at top level.

Test Plan:
- Single tile: tile_len=64, 64 consecutive writes, then 64 rd_req. Expect addresses 0..63; tile_done at cycle 65; rd_data_valid one cycle after each rd_gnt; rd_last on beat 64; all_empty=1 afterwards.
- Ping-pong: tile_len=16, write 48 words with no reads. Expect writes to banks 0 and 1 (addresses 0-15 and 64-79); wr_ready=0 and all_full=1 from word 33. Read 16 words, then wr_ready=1 the cycle after rd_last and writes resume at address 0.
- Conflict: wr_valid and rd_req both high for 8 cycles with bank 1 FULL. Expect all 8 writes accepted, rd_gnt=0, then reads proceed at addresses 64.. with no loss.
- Length edge cases: tile_len=0 gives 64 entries; tile_len=100 gives 64; tile_len=1 makes tile_done pulse after one write.
- Reset mid-drain: assert reset after 5 of 16 reads. Expect sram_cen=1, rd_data_valid=0 the next cycle, all_empty=1, and the next write goes to address 0.
- PSUM_TILE_STATS_EN: 3 tiles written and 2 drained gives tiles_written=3 and tiles_drained=2; both read 0 after reset.

Source files
------------

// File: rtl/psum_pkg.sv
`default_nettype none
// ============================================================================
// Module   : psum_pkg
// Brief    : Shared types and constants for the partial-sum bank controller.
// Revision : 1.0 - initial release
// ============================================================================
package psum_pkg;

  // Per-bank life cycle: filled by the writer, then drained by the loader.
  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  localparam int PSUM_BANK_DEPTH_DEF = 64;
  localparam int PSUM_NUM_BANK_DEF   = 2;

  // Ceiling log2 for elaboration-time widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/psum_bank_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : psum_bank_ctrl_if
// Brief    : Writer/loader handshakes, SRAM port and status of psum_bank_ctrl.
//            PSUM_TILE_STATS_EN adds the tiles_written/tiles_drained counters.
// Revision : 1.0 - initial release
// ============================================================================
interface psum_bank_ctrl_if #(
  parameter int ADD_WIDTH = 11,
  parameter int LEN_W     = 7
);
  logic [LEN_W-1:0]     tile_len;
  logic                 wr_valid;
  logic                 wr_ready;
  logic                 rd_req;
  logic                 rd_gnt;
  logic                 rd_data_valid;
  logic                 rd_last;
  logic                 sram_cen;
  logic                 sram_wen;
  logic [ADD_WIDTH-1:0] sram_addr;
  logic                 tile_done;
  logic                 tile_ready;
  logic                 all_full;
  logic                 all_empty;
`ifdef PSUM_TILE_STATS_EN
  logic [15:0]          tiles_written;
  logic [15:0]          tiles_drained;

  modport master (
    output tile_len, wr_valid, rd_req,
    input  wr_ready, rd_gnt, rd_data_valid, rd_last, sram_cen, sram_wen,
           sram_addr, tile_done, tile_ready, all_full, all_empty,
           tiles_written, tiles_drained
  );
  modport slave (
    input  tile_len, wr_valid, rd_req,
    output wr_ready, rd_gnt, rd_data_valid, rd_last, sram_cen, sram_wen,
           sram_addr, tile_done, tile_ready, all_full, all_empty,
           tiles_written, tiles_drained
  );
`else
  modport master (
    output tile_len, wr_valid, rd_req,
    input  wr_ready, rd_gnt, rd_data_valid, rd_last, sram_cen, sram_wen,
           sram_addr, tile_done, tile_ready, all_full, all_empty
  );
  modport slave (
    input  tile_len, wr_valid, rd_req,
    output wr_ready, rd_gnt, rd_data_valid, rd_last, sram_cen, sram_wen,
           sram_addr, tile_done, tile_ready, all_full, all_empty
  );
`endif
endinterface
`default_nettype wire

// File: rtl/psum_bank_fsm.sv
`default_nettype none
// ============================================================================
// Module   : psum_bank_fsm
// Brief    : State and stored tile length of one psum bank.
// Revision : 1.0 - initial release
// ============================================================================
module psum_bank_fsm
  import psum_pkg::*;
#(
  parameter int LEN_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_first_i,   // first write of a tile lands here
  input  logic             wr_last_i,    // last write of a tile lands here
  input  logic             rd_take_i,    // a read was granted from this bank
  input  logic             rd_last_i,    // that read was the last of the tile
  input  logic [LEN_W-1:0] len_i,
  output bank_state_t      state_o,
  output logic [LEN_W-1:0] len_o
);

  bank_state_t      state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;

  // Next state: a one-word tile is both first and last, so last wins.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    if (wr_first_i) begin
      state_d = FILLING;
      len_d   = len_i;
    end
    if (wr_last_i) state_d = FULL;
    if (rd_take_i) state_d = DRAINING;
    if (rd_last_i) state_d = EMPTY;
  end

  // State and length registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
    end
  end

  assign state_o = state_q;
  assign len_o   = len_q;

endmodule
`default_nettype wire

// File: rtl/psum_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : psum_bank_ctrl
// Brief    : Ping-pong bank controller for the single-port psum SRAM.
//            Writes win over reads; reads see data one cycle after rd_gnt.
//            Optional macro PSUM_TILE_STATS_EN adds tile counters.
// Revision : 1.0 - initial release
// ============================================================================
module psum_bank_ctrl
  import psum_pkg::*;
#(
  parameter int NUM_BANK   = PSUM_NUM_BANK_DEF,
  parameter int BANK_DEPTH = PSUM_BANK_DEPTH_DEF,
  parameter int ADD_WIDTH  = 11,
  parameter int LEN_W      = 7
) (
  input  logic             clk,
  input  logic             reset,
  psum_bank_ctrl_if.slave  bus
);

  localparam int              BW        = clog2(NUM_BANK);
  localparam int              CW        = clog2(BANK_DEPTH);
  localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(BANK_DEPTH);

  logic [BW-1:0]        wr_bank_q, rd_bank_q;
  logic [CW-1:0]        wr_cnt_q, rd_cnt_q;
  logic                 tile_done_q, rd_dv_q, rd_last_q;
  logic [ADD_WIDTH-1:0] addr_q;

  bank_state_t          bank_st  [NUM_BANK];
  logic [LEN_W-1:0]     bank_len [NUM_BANK];

  bank_state_t          wr_st, rd_st;
  logic                 wr_ready, wr_hs, wr_first, wr_last;
  logic                 rd_ready, rd_gnt, rd_last;
  logic                 all_empty_st;
  logic [LEN_W-1:0]     eff_len, wr_len;
  logic [ADD_WIDTH-1:0] wr_addr, rd_addr, addr_d;

  // Arbitration, tile-end detection and SRAM address selection.
  always_comb begin
    wr_st    = bank_st[wr_bank_q];
    rd_st    = bank_st[rd_bank_q];
    eff_len  = bus.tile_len;
    if (bus.tile_len == '0 || bus.tile_len > DEPTH_LEN) eff_len = DEPTH_LEN;
    wr_first = (wr_cnt_q == '0);
    // The bank's own length is not latched until its first write.
    wr_len   = wr_first ? eff_len : bank_len[wr_bank_q];
    wr_last  = (LEN_W'(wr_cnt_q) == wr_len - LEN_W'(1));
    wr_ready = !reset && (wr_st == EMPTY || wr_st == FILLING);
    wr_hs    = wr_ready && bus.wr_valid;
    rd_ready = (rd_st == FULL || rd_st == DRAINING);
    rd_gnt   = !reset && bus.rd_req && rd_ready && !wr_hs;
    rd_last  = (LEN_W'(rd_cnt_q) == bank_len[rd_bank_q] - LEN_W'(1));
    // Banks are power-of-two sized, so base + offset is a concatenation.
    wr_addr  = ADD_WIDTH'({wr_bank_q, wr_cnt_q});
    rd_addr  = ADD_WIDTH'({rd_bank_q, rd_cnt_q});
    addr_d   = wr_hs ? wr_addr : rd_addr;
    all_empty_st = 1'b1;
    for (int i = 0; i < NUM_BANK; i++) begin
      if (bank_st[i] != EMPTY) all_empty_st = 1'b0;
    end
  end

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    logic sel_wr, sel_rd;
    assign sel_wr = wr_hs  && (wr_bank_q == BW'(b));
    assign sel_rd = rd_gnt && (rd_bank_q == BW'(b));

    psum_bank_fsm #(.LEN_W(LEN_W)) u_fsm (
      .clk        (clk),
      .reset      (reset),
      .wr_first_i (sel_wr && wr_first),
      .wr_last_i  (sel_wr && wr_last),
      .rd_take_i  (sel_rd),
      .rd_last_i  (sel_rd && rd_last),
      .len_i      (eff_len),
      .state_o    (bank_st[b]),
      .len_o      (bank_len[b])
    );
  end

  // Pointers, counters and the one-cycle-delayed read/done flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank_q   <= '0;
      rd_bank_q   <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      tile_done_q <= 1'b0;
      rd_dv_q     <= 1'b0;
      rd_last_q   <= 1'b0;
      addr_q      <= '0;
    end else begin
      if (wr_hs) begin
        if (wr_last) begin
          wr_cnt_q  <= '0;
          wr_bank_q <= wr_bank_q + BW'(1);
        end else begin
          wr_cnt_q  <= wr_cnt_q + CW'(1);
        end
      end
      if (rd_gnt) begin
        if (rd_last) begin
          rd_cnt_q  <= '0;
          rd_bank_q <= rd_bank_q + BW'(1);
        end else begin
          rd_cnt_q  <= rd_cnt_q + CW'(1);
        end
      end
      tile_done_q <= wr_hs && wr_last;
      rd_dv_q     <= rd_gnt;
      rd_last_q   <= rd_gnt && rd_last;
      if (wr_hs || rd_gnt) addr_q <= addr_d;
    end
  end

  assign bus.wr_ready      = wr_ready;
  assign bus.rd_gnt        = rd_gnt;
  assign bus.rd_data_valid = rd_dv_q && !reset;
  assign bus.rd_last       = rd_last_q && !reset;
  assign bus.sram_cen      = !(wr_hs || rd_gnt);
  assign bus.sram_wen      = !wr_hs;
  assign bus.sram_addr     = (wr_hs || rd_gnt) ? addr_d : (reset ? '0 : addr_q);
  assign bus.tile_done     = tile_done_q && !reset;
  assign bus.tile_ready    = rd_ready && !reset;
  assign bus.all_full      = !reset && !(wr_st == EMPTY || wr_st == FILLING);
  assign bus.all_empty     = reset || all_empty_st;

`ifdef PSUM_TILE_STATS_EN
  logic [15:0] tiles_written_q, tiles_drained_q;

  // Completed-tile counters; they wrap freely.
  always_ff @(posedge clk) begin
    if (reset) begin
      tiles_written_q <= '0;
      tiles_drained_q <= '0;
    end else begin
      if (tile_done_q)             tiles_written_q <= tiles_written_q + 16'd1;
      if (rd_dv_q && rd_last_q)    tiles_drained_q <= tiles_drained_q + 16'd1;
    end
  end

  assign bus.tiles_written = tiles_written_q;
  assign bus.tiles_drained = tiles_drained_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_psum_bank_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_psum_bank_ctrl
// Brief    : Self-checking bench for psum_bank_ctrl (2 banks x 64 entries).
//            Checks PSUM_TILE_STATS_EN counters when that macro is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_psum_bank_ctrl;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  psum_bank_ctrl_if #(.ADD_WIDTH(11), .LEN_W(7)) bus ();

  psum_bank_ctrl #(
    .NUM_BANK   (2),
    .BANK_DEPTH (64),
    .ADD_WIDTH  (11),
    .LEN_W      (7)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic        wr_ready;
    logic        rd_gnt;
    logic        rdv;
    logic        rd_last;
    logic        cen;
    logic        wen;
    logic [10:0] addr;
    logic        tile_done;
    logic        tile_ready;
    logic        all_full;
    logic        all_empty;
  } obs_t;

  typedef struct {
    logic [6:0] tl;
    int         n;
  } len_vec_t;

  int   total = 0;
  int   bad   = 0;
  logic sb[$];          // expected rd_last for each granted read

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: drive, sample on the falling edge, score read beats, advance.
  task automatic step(input logic wv, input logic rq, input logic [6:0] tl,
                      input logic exp_last, output obs_t o);
    logic e;
    bus.wr_valid = wv;
    bus.rd_req   = rq;
    bus.tile_len = tl;
    @(negedge clk);
    o.wr_ready   = bus.wr_ready;
    o.rd_gnt     = bus.rd_gnt;
    o.rdv        = bus.rd_data_valid;
    o.rd_last    = bus.rd_last;
    o.cen        = bus.sram_cen;
    o.wen        = bus.sram_wen;
    o.addr       = bus.sram_addr;
    o.tile_done  = bus.tile_done;
    o.tile_ready = bus.tile_ready;
    o.all_full   = bus.all_full;
    o.all_empty  = bus.all_empty;
    if (reset) begin
      sb.delete();
    end else begin
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rd_beat", 32'({o.rdv, o.rd_last}), 32'({1'b1, e}));
      end else begin
        chk("rdv_idle", 32'(o.rdv), 32'd0);
      end
      if (o.rd_gnt) sb.push_back(exp_last);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    obs_t o;
    reset = 1'b1;
    step(1'b1, 1'b1, 7'd5, 1'b0, o);
    chk("rst_outputs",
        32'({o.wr_ready, o.rd_gnt, o.rdv, o.rd_last, o.cen, o.wen, o.addr, o.tile_done, o.all_empty}),
        32'({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 11'd0, 1'b0, 1'b1}));
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    obs_t     o;
    len_vec_t lv[6];
    int       cnt;
    bit       seen;

    lv[0] = '{7'd0,   64};
    lv[1] = '{7'd100, 64};
    lv[2] = '{7'd1,   1};
    lv[3] = '{7'd64,  64};
    lv[4] = '{7'd65,  64};
    lv[5] = '{7'd16,  16};

    bus.wr_valid = 1'b0;
    bus.rd_req   = 1'b0;
    bus.tile_len = 7'd0;

    // Single 64-entry tile written then drained.
    do_reset();
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 1'b0, 7'd64, 1'b0, o);
      chk("t1_wr", 32'({o.wr_ready, o.cen, o.wen, o.addr, o.tile_done}),
                   32'({1'b1, 1'b0, 1'b0, 11'(i), 1'b0}));
    end
    step(1'b0, 1'b0, 7'd64, 1'b0, o);
    chk("t1_done", 32'({o.tile_done, o.tile_ready, o.all_full, o.cen}),
                   32'({1'b1, 1'b1, 1'b0, 1'b1}));
    for (int i = 0; i < 64; i++) begin
      step(1'b0, 1'b1, 7'd64, (i == 63), o);
      chk("t1_rd", 32'({o.rd_gnt, o.cen, o.wen, o.addr}), 32'({1'b1, 1'b0, 1'b1, 11'(i)}));
    end
    step(1'b0, 1'b0, 7'd64, 1'b0, o);
    chk("t1_empty", 32'({o.all_empty, o.tile_ready, o.cen, o.addr}),
                    32'({1'b1, 1'b0, 1'b1, 11'd63}));

    // Ping-pong fill of both banks, then back-pressure until bank 0 drains.
    do_reset();
    for (int i = 0; i < 48; i++) begin
      step(1'b1, 1'b0, 7'd16, 1'b0, o);
      if (i < 32)
        chk("t2_wr", 32'({o.wr_ready, o.all_full, o.cen, o.addr}),
                     32'({1'b1, 1'b0, 1'b0, (i < 16) ? 11'(i) : 11'(48 + i)}));
      else
        chk("t2_full", 32'({o.wr_ready, o.all_full, o.cen, o.addr}),
                       32'({1'b0, 1'b1, 1'b1, 11'd79}));
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 7'd16, (i == 15), o);
      chk("t2_rd", 32'({o.rd_gnt, o.wr_ready, o.wen, o.addr}), 32'({1'b1, 1'b0, 1'b1, 11'(i)}));
    end
    step(1'b1, 1'b0, 7'd16, 1'b0, o);
    chk("t2_resume", 32'({o.wr_ready, o.cen, o.wen, o.addr, o.rdv, o.rd_last}),
                     32'({1'b1, 1'b0, 1'b0, 11'd0, 1'b1, 1'b1}));

    // Write/read conflict while bank 1 is full: writes win, reads then follow.
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 7'd16, 1'b0, o);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 7'd16, (i == 15), o);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 7'd16, 1'b0, o);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 7'd16, 1'b0, o);
      chk("t3_conf", 32'({o.wr_ready, o.rd_gnt, o.wen, o.tile_ready, o.addr}),
                     32'({1'b1, 1'b0, 1'b0, 1'b1, 11'(i)}));
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 7'd16, (i == 15), o);
      chk("t3_rd", 32'({o.rd_gnt, o.wen, o.addr}), 32'({1'b1, 1'b1, 11'(64 + i)}));
    end
    step(1'b0, 1'b0, 7'd16, 1'b0, o);

    // Tile-length table: effective length, addresses and rd_last placement.
    do_reset();
    for (int v = 0; v < 6; v++) begin
      cnt  = 0;
      seen = 1'b0;
      for (int k = 0; k < 70 && !seen; k++) begin
        step(1'b1, 1'b0, lv[v].tl, 1'b0, o);
        chk("t4_wr", 32'({o.wr_ready, o.wen, o.addr}),
                     32'({1'b1, 1'b0, 11'((v % 2) * 64 + cnt)}));
        cnt++;
        step(1'b0, 1'b0, lv[v].tl, 1'b0, o);
        if (o.tile_done) seen = 1'b1;
      end
      chk("t4_len", 32'(cnt), 32'(lv[v].n));
      for (int i = 0; i < lv[v].n; i++) begin
        step(1'b0, 1'b1, lv[v].tl, (i == lv[v].n - 1), o);
        chk("t4_rd", 32'({o.rd_gnt, o.addr}), 32'({1'b1, 11'((v % 2) * 64 + i)}));
      end
      step(1'b0, 1'b0, lv[v].tl, 1'b0, o);
      chk("t4_empty", 32'(o.all_empty), 32'd1);
    end

    // Reset in the middle of a drain drops the in-flight read.
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 7'd16, 1'b0, o);
    for (int i = 0; i < 5; i++)  step(1'b0, 1'b1, 7'd16, 1'b0, o);
    reset = 1'b1;
    step(1'b0, 1'b1, 7'd16, 1'b0, o);
    chk("t5_in_rst", 32'({o.rd_gnt, o.rdv, o.cen, o.addr}), 32'({1'b0, 1'b0, 1'b1, 11'd0}));
    reset = 1'b0;
    step(1'b0, 1'b0, 7'd16, 1'b0, o);
    chk("t5_after", 32'({o.cen, o.rdv, o.all_empty, o.tile_ready}),
                    32'({1'b1, 1'b0, 1'b1, 1'b0}));
    step(1'b1, 1'b0, 7'd16, 1'b0, o);
    chk("t5_wr0", 32'({o.wr_ready, o.wen, o.addr}), 32'({1'b1, 1'b0, 11'd0}));

`ifdef PSUM_TILE_STATS_EN
    // Three one-word tiles written, two drained.
    do_reset();
    chk("st_rst0", 32'({bus.tiles_written, bus.tiles_drained}), 32'd0);
    step(1'b1, 1'b0, 7'd1, 1'b0, o);
    step(1'b1, 1'b0, 7'd1, 1'b0, o);
    step(1'b0, 1'b1, 7'd1, 1'b1, o);
    step(1'b1, 1'b0, 7'd1, 1'b0, o);
    step(1'b0, 1'b1, 7'd1, 1'b1, o);
    step(1'b0, 1'b0, 7'd1, 1'b0, o);
    step(1'b0, 1'b0, 7'd1, 1'b0, o);
    chk("st_cnt", 32'({bus.tiles_written, bus.tiles_drained}), 32'({16'd3, 16'd2}));
    do_reset();
    chk("st_rst1", 32'({bus.tiles_written, bus.tiles_drained}), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
